// File: rtl/data_mem_responder_if.sv
// Memory-operation handshake bundle between an initiator and data_mem_responder.
interface data_mem_responder_if #(
    parameter int unsigned AW = 8
);
    logic          mov;
    logic          rw;
    logic [1:0]    size;
    logic          sign_ext;
    logic [AW-1:0] addr;
    logic [31:0]   data_in;
    logic [31:0]   data_out;
    logic          moc;
    logic          err;

    modport master (
        output mov, rw, size, sign_ext, addr, data_in,
        input  data_out, moc, err
    );

    modport slave (
        input  mov, rw, size, sign_ext, addr, data_in,
        output data_out, moc, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency big-endian byte memory with a four-phase mov/moc handshake
// and alignment checking.
module data_mem_responder #(
    parameter int unsigned MEM_BYTES = 256,
    parameter int unsigned LATENCY   = 3
) (
    input logic                clk,
    input logic                rst_n,
    data_mem_responder_if.slave bus
);
    localparam int unsigned AW   = $clog2(MEM_BYTES);
    localparam int unsigned CntW = 4;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            rw_q;
    logic [1:0]      size_q;
    logic            sign_ext_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     data_in_q;
    logic            moc_q;
    logic            err_q;
    logic [31:0]     data_out_q;

    logic [7:0]      mem [MEM_BYTES];

    logic            legal;
    logic            commit;
    logic            we;
    logic [AW-1:0]   addr1, addr2, addr3;
    logic [7:0]      b0, b1, b2, b3;
    logic [31:0]     load_data;

    assign addr1 = addr_q + AW'(1);
    assign addr2 = addr_q + AW'(2);
    assign addr3 = addr_q + AW'(3);

    // Aligned accesses never cross the top of memory, so the wrapped offsets are harmless.
    assign b0 = mem[addr_q];
    assign b1 = mem[addr1];
    assign b2 = mem[addr2];
    assign b3 = mem[addr3];

    always_comb begin
        legal = 1'b0;
        case (size_q)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~addr_q[0];
            2'b10:   legal = (addr_q[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        load_data = '0;
        case (size_q)
            2'b00:   load_data = {{24{sign_ext_q & b0[7]}}, b0};
            2'b01:   load_data = {{16{sign_ext_q & b0[7]}}, b0, b1};
            default: load_data = {b0, b1, b2, b3};
        endcase
    end

    assign commit = (state_q == StWait) && (cnt_q == '0);
    assign we     = commit && legal && !rw_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rw_q       <= 1'b0;
            size_q     <= 2'b00;
            sign_ext_q <= 1'b0;
            addr_q     <= '0;
            data_in_q  <= '0;
            moc_q      <= 1'b0;
            err_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.mov) begin
                        rw_q       <= bus.rw;
                        size_q     <= bus.size;
                        sign_ext_q <= bus.sign_ext;
                        addr_q     <= bus.addr;
                        data_in_q  <= bus.data_in;
                        cnt_q      <= CntW'(LATENCY - 1);
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q <= StDone;
                        moc_q   <= 1'b1;
                        err_q   <= ~legal;
                        if (legal && rw_q) data_out_q <= load_data;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StDone: begin
                    if (!bus.mov) begin
                        moc_q   <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Storage is deliberately not reset; writes are gated by the FSM, which reset does clear.
    always_ff @(posedge clk) begin
        if (we) begin
            case (size_q)
                2'b00: mem[addr_q] <= data_in_q[7:0];
                2'b01: begin
                    mem[addr_q] <= data_in_q[15:8];
                    mem[addr1]  <= data_in_q[7:0];
                end
                default: begin
                    mem[addr_q] <= data_in_q[31:24];
                    mem[addr1]  <= data_in_q[23:16];
                    mem[addr2]  <= data_in_q[15:8];
                    mem[addr3]  <= data_in_q[7:0];
                end
            endcase
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.moc      = moc_q;
    assign bus.err      = err_q;
endmodule
